// File: rtl/serial_frame_receiver_if.sv
// Serial frame receiver bus: the serial line in, received byte, status pulses and frame progress out.
// The master side drives rx (transmitter / test driver); the slave side is the receiver itself.
interface serial_frame_receiver_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic [3:0]           bit_cnt;
   logic                 frame_err;
   logic                 parity_err;
   logic                 busy;

   modport master (
      output rx,
      input  data_out,
      input  data_valid,
      input  bit_cnt,
      input  frame_err,
      input  parity_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data_out,
      output data_valid,
      output bit_cnt,
      output frame_err,
      output parity_err,
      output busy
   );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial-to-byte receive stage on the transceiver loopback path.
// Frame: start(0), DATA_BITS data LSB first, optional even parity, stop(1).
// Optional feature macro: RX_PARITY_EN -- when defined, a parity slot is present and checked;
// when undefined, data goes straight to stop and parity_err stays 0.
// All outputs are registered; reset is synchronous and active-high.
module serial_frame_receiver #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_frame_receiver_if.slave bus
);

`ifdef RX_PARITY_EN
   localparam logic PARITY_EN    = 1'b1;
   localparam int   PARITY_SLOTS = 1;
`else
   localparam logic PARITY_EN    = 1'b0;
   localparam int   PARITY_SLOTS = 0;
`endif

   localparam int         FRAME_BITS    = DATA_BITS + 2 + PARITY_SLOTS;
   localparam logic [7:0] HALF_LAST     = 8'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0] BIT_LAST      = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] DATA_LAST_CNT = 4'(DATA_BITS);
   localparam logic [3:0] FRAME_CNT     = 4'(FRAME_BITS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Even parity: the parity bit that makes the total number of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

   logic                 rx_meta_r;
   logic                 rx_sync_r;      // synchronized line (rx_s)
   logic [1:0]           flush_r;        // counts the synchronizer flush after reset
   logic                 armed_r;
   state_t               state_r;
   logic [7:0]           cnt_r;
   logic [3:0]           bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_bad_r;
   logic [DATA_BITS-1:0] data_out_r;
   logic                 data_valid_r;
   logic                 frame_err_r;
   logic                 parity_err_r;
   logic                 busy_r;

   state_t               state_next_s;
   logic [7:0]           cnt_next_s;
   logic [3:0]           bit_cnt_next_s;
   logic [DATA_BITS-1:0] shift_next_s;
   logic                 par_bad_next_s;
   logic [DATA_BITS-1:0] data_out_next_s;
   logic                 data_valid_next_s;
   logic                 frame_err_next_s;
   logic                 parity_err_next_s;
   logic                 armed_next_s;
   logic                 busy_next_s;
   logic                 rx_valid_s;

   // The synchronizer flops come out of reset at 1 regardless of the line, so their
   // content is only trusted once two real samples have passed through.
   assign rx_valid_s = (flush_r == 2'd2);

   // Two-flop synchronizer for rx plus the post-reset flush counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         flush_r   <= 2'd0;
      end else begin
         rx_meta_r <= bus.rx;
         rx_sync_r <= rx_meta_r;
         if (flush_r != 2'd2) begin
            flush_r <= flush_r + 2'd1;
         end else begin
            flush_r <= flush_r;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state, sampling datapath and output pulse decode.
   always_comb begin
      state_next_s      = state_r;
      cnt_next_s        = cnt_r + 8'd1;
      bit_cnt_next_s    = bit_cnt_r;
      shift_next_s      = shift_r;
      par_bad_next_s    = par_bad_r;
      data_out_next_s   = data_out_r;
      data_valid_next_s = 1'b0;
      frame_err_next_s  = 1'b0;
      parity_err_next_s = 1'b0;
      armed_next_s      = armed_r | (rx_valid_s & rx_sync_r);

      case (state_r)
         ST_IDLE: begin
            cnt_next_s     = 8'd0;
            bit_cnt_next_s = 4'd0;
            par_bad_next_s = 1'b0;
            if (armed_r && !rx_sync_r) begin
               state_next_s = ST_START;
            end else begin
               state_next_s = ST_IDLE;
            end
         end

         ST_START: begin
            if (cnt_r == HALF_LAST) begin
               cnt_next_s = 8'd0;
               if (rx_sync_r) begin
                  // Line back high at mid-start: treat as a glitch.
                  state_next_s   = ST_IDLE;
                  bit_cnt_next_s = 4'd0;
               end else begin
                  state_next_s   = ST_DATA;
                  bit_cnt_next_s = 4'd1;
               end
            end else begin
               cnt_next_s = cnt_r + 8'd1;
            end
         end

         ST_DATA: begin
            if (cnt_r == BIT_LAST) begin
               cnt_next_s     = 8'd0;
               shift_next_s   = {rx_sync_r, shift_r[DATA_BITS-1:1]};
               bit_cnt_next_s = bit_cnt_r + 4'd1;
               if (bit_cnt_r == DATA_LAST_CNT) begin
                  state_next_s = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  state_next_s = ST_DATA;
               end
            end else begin
               cnt_next_s = cnt_r + 8'd1;
            end
         end

         ST_PARITY: begin
            if (cnt_r == BIT_LAST) begin
               cnt_next_s     = 8'd0;
               bit_cnt_next_s = bit_cnt_r + 4'd1;
               par_bad_next_s = PARITY_EN & (rx_sync_r ^ even_parity(shift_r));
               state_next_s   = ST_STOP;
            end else begin
               cnt_next_s = cnt_r + 8'd1;
            end
         end

         ST_STOP: begin
            if (cnt_r == BIT_LAST) begin
               cnt_next_s     = 8'd0;
               bit_cnt_next_s = bit_cnt_r + 4'd1;
               state_next_s   = ST_IDLE;
               if (rx_sync_r) begin
                  if (par_bad_r) begin
                     parity_err_next_s = 1'b1;
                  end else begin
                     data_valid_next_s = 1'b1;
                     data_out_next_s   = shift_r;
                  end
               end else begin
                  // Broken stop bit: disarm until the line is seen high again.
                  frame_err_next_s  = 1'b1;
                  parity_err_next_s = par_bad_r;
                  armed_next_s      = 1'b0;
               end
            end else begin
               cnt_next_s = cnt_r + 8'd1;
            end
         end

         default: begin
            state_next_s   = ST_IDLE;
            cnt_next_s     = 8'd0;
            bit_cnt_next_s = 4'd0;
         end
      endcase

      // Busy holds through the stop-sample cycle and drops on the following one.
      busy_next_s = (state_r != ST_IDLE) || (state_next_s != ST_IDLE);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_r      <= 1'b0;
         cnt_r        <= 8'd0;
         bit_cnt_r    <= 4'd0;
         shift_r      <= '0;
         par_bad_r    <= 1'b0;
         data_out_r   <= '0;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         parity_err_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         armed_r      <= armed_next_s;
         cnt_r        <= cnt_next_s;
         bit_cnt_r    <= bit_cnt_next_s;
         shift_r      <= shift_next_s;
         par_bad_r    <= par_bad_next_s;
         data_out_r   <= data_out_next_s;
         data_valid_r <= data_valid_next_s;
         frame_err_r  <= frame_err_next_s;
         parity_err_r <= parity_err_next_s;
         busy_r       <= busy_next_s;
      end
   end

   assign bus.data_out   = data_out_r;
   assign bus.data_valid = data_valid_r;
   assign bus.bit_cnt    = bit_cnt_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.parity_err = parity_err_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver (CLKS_PER_BIT=4, DATA_BITS=8).
// Follows RX_PARITY_EN the same way the design does, so it suits either build.
module tb_serial_frame_receiver;
   localparam int CPB = 4;
`ifdef RX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int FB = 8 + 2 + PAR_EN;

   typedef struct {
      int         at_cyc;
      logic       dv;
      logic       fe;
      logic       pe;
      logic [7:0] d;
      logic [3:0] bc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_frame_receiver_if #(.DATA_BITS(8)) bus ();

   serial_frame_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge n, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Capture (write-only here): per-edge {busy, bit_cnt} log and the pulse events.
   logic [4:0] st_log[$];
   ev_t        obs_q[$];
   always @(negedge clk) begin
      ev_t o;
      st_log.push_back({bus.busy, bus.bit_cnt});
      if (bus.data_valid === 1'b1 || bus.frame_err === 1'b1 || bus.parity_err === 1'b1) begin
         o.at_cyc = cyc;
         o.dv     = bus.data_valid;
         o.fe     = bus.frame_err;
         o.pe     = bus.parity_err;
         o.d      = bus.data_out;
         o.bc     = bus.bit_cnt;
         obs_q.push_back(o);
      end
   end

   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;
   int         obs_rd  = 0;
   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] log_at(input int edge_n);
      if (edge_n >= 1 && edge_n - 1 < st_log.size()) return st_log[edge_n - 1];
      return 5'bxxxxx;
   endfunction

   function automatic int log_max_bc(input int a, input int b);
      int m = 0;
      for (int i = a; i <= b; i++) begin
         if (i >= 1 && i - 1 < st_log.size() && int'(st_log[i - 1][3:0]) > m) m = int'(st_log[i - 1][3:0]);
      end
      return m;
   endfunction

   function automatic int log_any_busy(input int a, input int b);
      int any = 0;
      for (int i = a; i <= b; i++) begin
         if (i >= 1 && i - 1 < st_log.size() && st_log[i - 1][4] === 1'b1) any = 1;
      end
      return any;
   endfunction

   // Hold rx at a level for n cycles; entered and left at posedge+1.
   task automatic hold(input logic level, input int n);
      bus.rx = level;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame and queue the outcome the frame rules predict.
   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
      ev_t  e;
      logic pbit;
      int   k;
      k        = cyc + 1;
      pbit     = par_ok ? (^d) : ~(^d);
      e.at_cyc = k + 2 + CPB / 2 + (FB - 1) * CPB;
      e.bc     = 4'(FB);
      if (!stop) begin
         e.dv = 1'b0; e.fe = 1'b1; e.pe = (PAR_EN != 0) && !par_ok; e.d = last_good;
      end else if ((PAR_EN != 0) && !par_ok) begin
         e.dv = 1'b0; e.fe = 1'b0; e.pe = 1'b1; e.d = last_good;
      end else begin
         e.dv = 1'b1; e.fe = 1'b0; e.pe = 1'b0; e.d = d;
         last_good = d;
      end
      exp_q.push_back(e);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
      if (PAR_EN != 0) hold(pbit, CPB);
      hold(stop, CPB);
   endtask

   task automatic check_events(input string tag);
      int n_obs;
      n_obs = obs_q.size() - obs_rd;
      chk($sformatf("%s_event_count", tag), 32'(n_obs), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n_obs) begin
            ev_t o;
            ev_t e;
            o = obs_q[obs_rd + i];
            e = exp_q[i];
            chk($sformatf("%s_ev%0d_cycle", tag, i), 32'(o.at_cyc), 32'(e.at_cyc));
            chk($sformatf("%s_ev%0d_valid", tag, i), 32'(o.dv), 32'(e.dv));
            chk($sformatf("%s_ev%0d_frame_err", tag, i), 32'(o.fe), 32'(e.fe));
            chk($sformatf("%s_ev%0d_parity_err", tag, i), 32'(o.pe), 32'(e.pe));
            chk($sformatf("%s_ev%0d_data", tag, i), 32'(o.d), 32'(e.d));
            chk($sformatf("%s_ev%0d_bit_cnt", tag, i), 32'(o.bc), 32'(e.bc));
         end
      end
      obs_rd = obs_q.size();
      exp_q.delete();
   endtask

   initial begin
      int         k;
      int         ev;
      int         t0;
      int         found;
      logic [7:0] rd;
      logic       rpok;
      logic       rstop;

      // Reset state
      bus.rx = 1'b1;
      rst    = 1'b1;
      hold(1'b1, 3);
      chk("rst_data_out", 32'(bus.data_out), 32'h0);
      chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
      chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'h0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
      chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      hold(1'b1, 6);

      // Test 1: single 0xA5
      k  = cyc + 1;
      ev = k + 2 + CPB / 2 + (FB - 1) * CPB;
      send_frame(8'hA5, 1'b1, 1'b1);
      hold(1'b1, 12);
      check_events("t1");
      chk("t1_busy_before_detect", 32'(log_at(k + 1) >> 4), 32'h0);
      chk("t1_busy_at_detect", 32'(log_at(k + 2) >> 4), 32'h1);
      chk("t1_state_at_stop", 32'(log_at(ev)), 32'({1'b1, 4'(FB)}));
      chk("t1_state_after_stop", 32'(log_at(ev + 1)), 32'h0);
      chk("t1_bit_cnt_peak", 32'(log_max_bc(k, cyc - 1)), 32'(FB));
      chk("t1_data_out_hold", 32'(bus.data_out), 32'hA5);

      // Test 2: back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      hold(1'b1, 12);
      check_events("t2");
      chk("t2_data_out_hold", 32'(bus.data_out), 32'h3C);

      // Test 3: broken stop bit, line held low, then a good frame
      send_frame(8'h81, 1'b1, 1'b0);
      t0 = cyc;
      hold(1'b0, 20);
      chk("t3_no_restart_while_low", 32'(log_any_busy(t0 + 3, cyc - 1)), 32'h0);
      chk("t3_bit_cnt_low", 32'(bus.bit_cnt), 32'h0);
      chk("t3_data_out_kept", 32'(bus.data_out), 32'h3C);
      hold(1'b1, CPB);
      send_frame(8'h12, 1'b1, 1'b1);
      hold(1'b1, 12);
      check_events("t3");
      chk("t3_data_out_new", 32'(bus.data_out), 32'h12);

`ifdef RX_PARITY_EN
      // Test 4: bad parity on 0x07
      send_frame(8'h07, 1'b0, 1'b1);
      hold(1'b1, 12);
      check_events("t4");
      chk("t4_data_out_kept", 32'(bus.data_out), 32'h12);
`endif

      // Test 5: one-cycle low glitch
      k = cyc + 1;
      hold(1'b0, 1);
      hold(1'b1, 10);
      chk("t5_glitch_seen", 32'(log_at(k + 2) >> 4), 32'h1);
      chk("t5_busy_dropped", 32'(bus.busy), 32'h0);
      chk("t5_bit_cnt_peak", 32'(log_max_bc(k, cyc - 1)), 32'h0);
      check_events("t5");
      chk("t5_data_out_kept", 32'(bus.data_out), 32'(last_good));

      // Test 6: reset mid-frame with the line low
      bus.rx = 1'b0;
      found  = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         @(negedge clk);
         if (bus.bit_cnt === 4'd5) found = 1;
      end
      chk("t6_reached_bit5", 32'(found), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      last_good = 8'h00;
      chk("t6_data_out", 32'(bus.data_out), 32'h0);
      chk("t6_bit_cnt", 32'(bus.bit_cnt), 32'h0);
      chk("t6_busy", 32'(bus.busy), 32'h0);
      t0 = cyc;
      hold(1'b0, 12);
      chk("t6_no_false_start", 32'(log_any_busy(t0 + 1, cyc - 1)), 32'h0);
      chk("t6_bit_cnt_low", 32'(bus.bit_cnt), 32'h0);
      hold(1'b1, CPB);
      send_frame(8'h5A, 1'b1, 1'b1);
      hold(1'b1, 12);
      check_events("t6");
      chk("t6_data_out_new", 32'(bus.data_out), 32'h5A);

      // Randomized frames against the frame-rule model
      for (int f = 0; f < 16; f++) begin
         rd    = 8'($urandom);
         rpok  = (PAR_EN != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         rstop = ($urandom_range(0, 5) != 0);
         send_frame(rd, rpok, rstop);
         if (!rstop) begin
            hold(1'b0, int'($urandom_range(0, 8)));
            hold(1'b1, CPB);
         end else begin
            hold(1'b1, int'($urandom_range(0, 3)));
         end
      end
      hold(1'b1, 12);
      check_events("rand");
      chk("rand_data_out_hold", 32'(bus.data_out), 32'(last_good));
      chk("rand_idle_bit_cnt", 32'(bus.bit_cnt), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
